hamming_seq_ctrl: RTL and testbench
===================================

Name: hamming_seq_ctrl

Overview:
Sequencing controller for Hamming-distance computation over a frame of WORDS 16-bit operand pairs. It holds one 4-bit Hamming-distance unit and one 8-bit accumulator adder. Each accepted pair is walked nibble by nibble (4 cycles), and the per-nibble distances are summed across the frame. The frame total is presented on a valid/ready result interface, so a single narrow datapath replaces the parallel 16-bit tree wherever area matters more than throughput.

Parameters:
WORDS, 4, operand pairs per frame; legal range 1..15 (maximum total 240 fits in 8 bits).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
A  input  16  operand A, sampled on accept
B  input  16  operand B, sampled on accept
IN_VALID  input  1  A/B pair offered
IN_READY  output  1  controller can accept a pair (decoded from state)
ABORT  input  1  synchronous frame abort
DIST  output  8  frame Hamming distance; valid while OUT_VALID
OUT_VALID  output  1  result available
OUT_READY  input  1  consumer takes result
BUSY  output  1  frame in progress (word count nonzero or in CALC/DONE)

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, acc=0, word_cnt=0, nib=3, A/B regs=0.
  - DIST=0, OUT_VALID=0, BUSY=0; IN_READY reads 1 once state is IDLE.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - IN_READY=1.
  - Accept = IN_VALID & IN_READY at a rising edge. On accept, latch A,B, set nib=3, go CALC.
  - Without IN_VALID, stay in IDLE and hold acc and word_cnt.
- CALC:
  - IN_READY=0. One nibble per cycle, MSB nibble first (nib 3,2,1,0).
  - Each cycle: acc <= acc + zero-extend(popcount(A_reg[nib] xor B_reg[nib])). The 3-bit nibble result is extended to 8 bits; no saturation is needed given the WORDS range.
  - On the nib=0 cycle: word_cnt <= word_cnt+1. If word_cnt+1 == WORDS go DONE, else go IDLE.
- DONE:
  - OUT_VALID=1 and DIST=acc, both held stable until OUT_READY=1.
  - On the OUT_READY edge: acc=0, word_cnt=0, OUT_VALID=0, go IDLE.
  - OUT_READY while not in DONE is ignored.
- Latency and throughput:
  - Per pair: accept edge, then 4 CALC cycles. Throughput is 1 pair per 5 cycles with IN_VALID held high.
  - OUT_VALID rises at the 4th edge after the final accept edge.
- ABORT: sampled every edge and has priority over accept, CALC and DONE. It forces IDLE, acc=0, word_cnt=0 and OUT_VALID=0. A result not yet taken is discarded.
- Simultaneous events:
  - In DONE, OUT_READY together with IN_VALID: the result is taken and the pair is NOT accepted that edge, because IN_READY=0 in DONE. The pair is accepted next cycle.
  - ABORT together with an IN_VALID accept: the pair is dropped.
- Operand stability: A and B may change freely after the accept edge; only the latched copies are used.
- rst asserted mid-frame: immediate return to reset values, and partial sums are lost.

Optional Feature:
Macro HB_THRESHOLD_EN.
- Defined:
  - Adds input THRESH (8 bits) and output OVER (1 bit).
  - OVER = (acc > THRESH), registered on entry to DONE and valid with OUT_VALID. It clears together with OUT_VALID and resets to 0.
  - THRESH is sampled on the DONE-entry edge.
- Undefined: THRESH and OVER ports are absent; all other behaviour is identical.

Test Plan:
1. WORDS=4; A=16'hFFFF, B=16'h0000 on every pair; IN_VALID held high; OUT_READY=1.
   -> accepts at cycles 0,5,10,15; OUT_VALID at cycle 19 with DIST=8'h40; taken the same cycle.
2. WORDS=4; pairs (16'hA5A5 vs 16'h5A5A), (16'h0001 vs 16'h0000), (16'h1234 vs 16'h1234), (16'hF000 vs 16'h0F00).
   -> DIST = 16+1+0+8 = 8'h19.
3. Backpressure: scenario 1 with OUT_READY=0 for 10 cycles after OUT_VALID.
   -> DIST=8'h40 stays stable; IN_READY=0 throughout; the next frame starts only after OUT_READY.
4. ABORT pulse during the 2nd CALC cycle of pair 3.
   -> IDLE next cycle with BUSY=0; a following full frame of A=16'h000F, B=0 gives DIST=8'h10 (no stale sum).
5. rst asserted mid-CALC, asynchronously between edges.
   -> OUT_VALID=0, DIST=0, BUSY=0 immediately; IN_READY=1 after release.
6. HB_THRESHOLD_EN defined; scenario 2 frame with THRESH=8'h18 -> OVER=1; repeated with THRESH=8'h19 -> OVER=0.

Source files
------------

// File: rtl/hamming_seq_ctrl.sv
// Nibble-serial Hamming-distance frame controller: one 4-bit popcount unit and an 8-bit accumulator.
// Optional threshold compare output is enabled by defining HB_THRESHOLD_EN.
module hamming_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        ABORT,
  output logic [7:0]  DIST,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
`ifdef HB_THRESHOLD_EN
  input  logic [7:0]  THRESH,
  output logic        OVER,
`endif
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WORDS_C = 4'(WORDS);

  state_t      state, state_n;
  logic [15:0] a_p0, a_p0_n;
  logic [15:0] b_p0, b_p0_n;
  logic [1:0]  nib, nib_n;
  logic [7:0]  acc_p1, acc_p1_n;
  logic [3:0]  word_cnt, word_cnt_n;
  logic [3:0]  word_cnt_inc;
  logic [3:0]  a_nib, b_nib;
  logic [2:0]  nib_dist;
  logic [7:0]  acc_sum;
  logic        over_q, over_n;

  function automatic logic [2:0] popcount4(input logic [3:0] x);
    popcount4 = 3'(x[0]) + 3'(x[1]) + 3'(x[2]) + 3'(x[3]);
  endfunction

  function automatic logic [7:0] acc_add(input logic [7:0] acc, input logic [2:0] d);
    // WORDS <= 15 bounds the total at 240, so plain wrap-free addition is sufficient.
    acc_add = acc + {5'b0, d};
  endfunction

  always_comb begin
    a_nib        = a_p0[{nib, 2'b00} +: 4];
    b_nib        = b_p0[{nib, 2'b00} +: 4];
    nib_dist     = popcount4(a_nib ^ b_nib);
    acc_sum      = acc_add(acc_p1, nib_dist);
    word_cnt_inc = word_cnt + 4'd1;
  end

  always_comb begin
    state_n    = state;
    a_p0_n     = a_p0;
    b_p0_n     = b_p0;
    nib_n      = nib;
    acc_p1_n   = acc_p1;
    word_cnt_n = word_cnt;
    over_n     = over_q;

    if (ABORT) begin
      // Abort beats accept, accumulate and result handshake alike.
      state_n    = IDLE;
      nib_n      = 2'd3;
      acc_p1_n   = 8'd0;
      word_cnt_n = 4'd0;
      over_n     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_p0_n  = A;
            b_p0_n  = B;
            nib_n   = 2'd3;
            state_n = CALC;
          end
        end
        CALC: begin
          acc_p1_n = acc_sum;
          nib_n    = nib - 2'd1;
          if (nib == 2'd0) begin
            word_cnt_n = word_cnt_inc;
            if (word_cnt_inc == WORDS_C) begin
              state_n = DONE;
`ifdef HB_THRESHOLD_EN
              over_n  = (acc_sum > THRESH);
`endif
            end else begin
              state_n = IDLE;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            acc_p1_n   = 8'd0;
            word_cnt_n = 4'd0;
            over_n     = 1'b0;
            state_n    = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // ---- stage p0/p1: operand latch, nibble walk and frame accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_p0     <= 16'd0;
      b_p0     <= 16'd0;
      nib      <= 2'd3;
      acc_p1   <= 8'd0;
      word_cnt <= 4'd0;
      over_q   <= 1'b0;
    end else begin
      state    <= state_n;
      a_p0     <= a_p0_n;
      b_p0     <= b_p0_n;
      nib      <= nib_n;
      acc_p1   <= acc_p1_n;
      word_cnt <= word_cnt_n;
      over_q   <= over_n;
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign DIST      = acc_p1;
  assign BUSY      = (word_cnt != 4'd0) || (state != IDLE);

`ifdef HB_THRESHOLD_EN
  assign OVER = over_q;
`else
  logic unused_over;
  assign unused_over = over_q;
`endif

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Directed bench for hamming_seq_ctrl (WORDS=4); threshold checks are built when HB_THRESHOLD_EN is defined.
module tb_hamming_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        IN_VALID, IN_READY, ABORT;
  logic [7:0]  DIST;
  logic        OUT_VALID, OUT_READY, BUSY;
`ifdef HB_THRESHOLD_EN
  logic [7:0]  THRESH;
  logic        OVER;
`endif

  int n_vec = 0;
  int n_err = 0;

  hamming_seq_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ABORT(ABORT),
    .DIST(DIST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef HB_THRESHOLD_EN
    .THRESH(THRESH), .OVER(OVER),
`endif
    .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!IN_READY && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk_vec("send_ready_timeout", 32'(n < 40), 32'd1);
    A = a; B = b; IN_VALID = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!OUT_VALID && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk_vec({tag, "_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic take_result(input string tag, input logic [7:0] exp);
    wait_valid(tag);
    chk_vec(tag, 32'(DIST), 32'(exp));
    OUT_READY = 1'b1;
    @(posedge clk); #1;
    OUT_READY = 1'b0;
    chk_vec({tag, "_clr"}, 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; A = 16'd0; B = 16'd0;
    IN_VALID = 1'b0; ABORT = 1'b0; OUT_READY = 1'b0;
`ifdef HB_THRESHOLD_EN
    THRESH = 8'h00;
`endif
    #12;
    chk_vec("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk_vec("rst_dist", 32'(DIST), 32'd0);
    chk_vec("rst_busy", 32'(BUSY), 32'd0);
    chk_vec("rst_in_ready", 32'(IN_READY), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Scenario 1: back-to-back all-ones pairs, consumer always ready
    A = 16'hFFFF; B = 16'h0000; IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      chk_vec("s1_in_ready", 32'(IN_IDLE(k)), 32'(IN_READY) ^ 32'd0);
      chk_vec("s1_out_valid", 32'(OUT_VALID), 32'(k == 19));
      chk_vec("s1_busy", 32'(BUSY), 32'(k != 20));
      if (k == 19) begin
        chk_vec("s1_dist", 32'(DIST), 32'h40);
        IN_VALID = 1'b0;
      end
    end
    OUT_READY = 1'b0;

    // Scenario 2: mixed pairs, 16+1+0+8
    send_pair(16'hA5A5, 16'h5A5A);
    send_pair(16'h0001, 16'h0000);
    send_pair(16'h1234, 16'h1234);
    send_pair(16'hF000, 16'h0F00);
    take_result("s2_dist", 8'h19);

    // Scenario 3: backpressure holds the result and blocks new pairs
    for (int i = 0; i < 4; i++) send_pair(16'hFFFF, 16'h0000);
    wait_valid("s3");
    A = 16'hFFFF; B = 16'h0000; IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_vec("s3_dist_hold", 32'(DIST), 32'h40);
      chk_vec("s3_valid_hold", 32'(OUT_VALID), 32'd1);
      chk_vec("s3_in_ready", 32'(IN_READY), 32'd0);
    end
    OUT_READY = 1'b1;
    @(posedge clk); #1;
    OUT_READY = 1'b0;
    chk_vec("s3_taken", 32'(OUT_VALID), 32'd0);
    chk_vec("s3_ready_after", 32'(IN_READY), 32'd1);
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    chk_vec("s3_next_accept", 32'(IN_READY), 32'd0);
    chk_vec("s3_next_busy", 32'(BUSY), 32'd1);
    ABORT = 1'b1;
    @(posedge clk); #1;
    ABORT = 1'b0;
    chk_vec("s3_abort_busy", 32'(BUSY), 32'd0);

    // Scenario 4: abort on the 2nd CALC cycle of pair 3, then a clean frame
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'hFFFF, 16'h0000);
    @(posedge clk); #1;
    ABORT = 1'b1;
    @(posedge clk); #1;
    ABORT = 1'b0;
    chk_vec("s4_in_ready", 32'(IN_READY), 32'd1);
    chk_vec("s4_busy", 32'(BUSY), 32'd0);
    chk_vec("s4_out_valid", 32'(OUT_VALID), 32'd0);
    for (int i = 0; i < 4; i++) send_pair(16'h000F, 16'h0000);
    take_result("s4_dist", 8'h10);

    // Abort coinciding with an offered pair drops the pair
    A = 16'hFFFF; B = 16'h0000; IN_VALID = 1'b1; ABORT = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0; ABORT = 1'b0;
    chk_vec("abort_accept_ready", 32'(IN_READY), 32'd1);
    chk_vec("abort_accept_busy", 32'(BUSY), 32'd0);

    // Scenario 5: asynchronous reset in the middle of a CALC cycle
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'hFFFF, 16'h0000);
    #3;
    rst = 1'b1;
    #1;
    chk_vec("s5_out_valid", 32'(OUT_VALID), 32'd0);
    chk_vec("s5_dist", 32'(DIST), 32'd0);
    chk_vec("s5_busy", 32'(BUSY), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_vec("s5_in_ready", 32'(IN_READY), 32'd1);
    for (int i = 0; i < 4; i++) send_pair(16'h00FF, 16'h0000);
    take_result("s5_dist_after", 8'h20);

`ifdef HB_THRESHOLD_EN
    // Scenario 6: threshold compare against a 0x19 frame
    for (int t = 0; t < 2; t++) begin
      THRESH = (t == 0) ? 8'h18 : 8'h19;
      send_pair(16'hA5A5, 16'h5A5A);
      send_pair(16'h0001, 16'h0000);
      send_pair(16'h1234, 16'h1234);
      send_pair(16'hF000, 16'h0F00);
      wait_valid("s6");
      chk_vec("s6_over", 32'(OVER), 32'(t == 0));
      take_result("s6_dist", 8'h19);
      chk_vec("s6_over_clr", 32'(OVER), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hand model of IN_READY after edge k in scenario 1: accepts at 0,5,10,15, result at 19, taken at 20.
  function automatic logic IN_IDLE(input int k);
    IN_IDLE = ((k % 5 == 4) && (k != 19)) || (k == 20);
  endfunction

endmodule
